ti_polyphase_seq: RTL and testbench

- Front-end sequencer for the 8-lane time-interleaved polyphase decimation path.
- Accepts one serial stream of signed BW-bit ADC samples with a valid strobe.
- Deserialises the samples into 8 parallel lane words (IN1..IN8 order) and issues a frame strobe that clocks the path's delay registers.
- Suppresses output-valid until the path's one-frame history is primed, and flags frames that downstream fails to take.

---
 rtl/ti_polyphase_seq_if.sv | 28 ++
 rtl/ti_polyphase_seq.sv | 97 +++++++++
 tb/tb_ti_polyphase_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ti_polyphase_seq_if.sv
// Sample-in / frame-out bundle for the polyphase front-end sequencer.
// The master side drives samples and downstream status; the slave side is the sequencer.
interface ti_polyphase_seq_if #(
   parameter int BW    = 6,
   parameter int LANES = 8
);
   logic                   EN;
   logic                   IN_VLD;
   logic signed [BW-1:0]   IN_DAT;
   logic                   DS_RDY;
   logic                   OVF_CLR;
   logic [LANES*BW-1:0]    LANE_DAT;
   logic                   LANE_STB;
   logic                   OUT_VLD;
   logic [2:0]             PHASE;
   logic                   BUSY;
   logic                   OVF;

   modport master (
      output EN, IN_VLD, IN_DAT, DS_RDY, OVF_CLR,
      input  LANE_DAT, LANE_STB, OUT_VLD, PHASE, BUSY, OVF
   );

   modport slave (
      input  EN, IN_VLD, IN_DAT, DS_RDY, OVF_CLR,
      output LANE_DAT, LANE_STB, OUT_VLD, PHASE, BUSY, OVF
   );
endinterface

// File: rtl/ti_polyphase_seq.sv
// Deserialises a serial sample stream into 8-lane frames; LANE_STB one cycle after the 8th sample.
// No input backpressure: a frame not taken by downstream only sets the sticky OVF flag.
module ti_polyphase_seq #(
   parameter int BW    = 6,
   parameter int LANES = 8
) (
   input  logic              CLK,
   input  logic              RES,
   ti_polyphase_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [2:0] LAST = 3'(LANES - 1);

   state_t              state_q, state_d;
   logic [2:0]          phase_q, phase_d;
   logic                accept;
   logic                frame_done;
   logic [LANES*BW-1:0] asm_q;
   logic [LANES*BW-1:0] lane_dat_q;
   logic                lane_stb_q;
   logic                out_vld_q;
   logic                busy_q;
   logic                ovf_q;

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         state_q <= IDLE;
         phase_q <= 3'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   // Dropping EN wins over a sample that would have closed the frame.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      accept     = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            phase_d = 3'd0;
            if (bus.EN) state_d = FILL;
         end
         FILL, RUN: begin
            if (!bus.EN) begin
               state_d = IDLE;
               phase_d = 3'd0;
            end else if (bus.IN_VLD) begin
               accept  = 1'b1;
               phase_d = phase_q + 3'd1;
               if (phase_q == LAST) begin
                  frame_done = 1'b1;
                  state_d    = RUN;
               end
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = 3'd0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         asm_q      <= '0;
         lane_dat_q <= '0;
         lane_stb_q <= 1'b0;
         out_vld_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (accept) asm_q[int'(phase_q)*BW +: BW] <= bus.IN_DAT;
         // The closing sample bypasses the buffer so the frame lands with no bubble.
         if (frame_done) lane_dat_q <= {bus.IN_DAT, asm_q[(LANES-1)*BW-1:0]};
         lane_stb_q <= frame_done;
         out_vld_q  <= frame_done && (state_q == RUN);
         if (out_vld_q && !bus.DS_RDY) ovf_q <= 1'b1;
         else if (bus.OVF_CLR)         ovf_q <= 1'b0;
      end
   end

   assign bus.LANE_DAT = lane_dat_q;
   assign bus.LANE_STB = lane_stb_q;
   assign bus.OUT_VLD  = out_vld_q;
   assign bus.PHASE    = phase_q;
   assign bus.BUSY     = busy_q;
   assign bus.OVF      = ovf_q;
endmodule

// File: tb/tb_ti_polyphase_seq.sv
// Bench for ti_polyphase_seq: directed table, corner-case sequences and a random run
// checked every cycle against a queue-based frame model.
module tb_ti_polyphase_seq;
   localparam int BW = 6;
   localparam int LW = 8 * BW;

   logic CLK;
   logic RES;
   ti_polyphase_seq_if #(.BW(BW), .LANES(8)) bus ();

   ti_polyphase_seq #(.BW(BW), .LANES(8)) dut (
      .CLK (CLK),
      .RES (RES),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [LW-1:0] pack_seq(input int first);
      logic [LW-1:0] v;
      v = '0;
      for (int k = 0; k < 8; k++) v[k*BW +: BW] = BW'(first + k);
      return v;
   endfunction

   // Reference model: samples collect in a queue; eight of them make a frame.
   logic signed [BW-1:0] mq[$];
   bit            m_act, m_primed;
   logic [LW-1:0] e_dat;
   logic          e_stb, e_ovld, e_busy, e_ovf;
   logic [2:0]    e_phase;

   always @(posedge CLK or negedge RES) begin
      if (!RES) begin
         mq.delete();
         m_act = 0; m_primed = 0;
         e_dat = '0; e_stb = 0; e_ovld = 0; e_busy = 0; e_ovf = 0; e_phase = 3'd0;
      end else begin
         if (e_ovld && !bus.DS_RDY) e_ovf = 1'b1;
         else if (bus.OVF_CLR)      e_ovf = 1'b0;
         e_stb  = 1'b0;
         e_ovld = 1'b0;
         if (!m_act) begin
            if (bus.EN) begin
               m_act    = 1;
               m_primed = 0;
            end
         end else if (!bus.EN) begin
            m_act = 0;
            mq.delete();
         end else if (bus.IN_VLD) begin
            mq.push_back(bus.IN_DAT);
            if (mq.size() == 8) begin
               for (int k = 0; k < 8; k++) e_dat[k*BW +: BW] = mq[k];
               e_stb    = 1'b1;
               e_ovld   = m_primed;
               m_primed = 1;
               mq.delete();
            end
         end
         e_busy  = m_act;
         e_phase = 3'(mq.size());
      end
   end

   bit mon_on = 0;
   always @(negedge CLK) begin
      if (mon_on)
         chk("cycle_vs_model",
             64'({bus.LANE_DAT, bus.LANE_STB, bus.OUT_VLD, bus.PHASE, bus.BUSY, bus.OVF}),
             64'({e_dat, e_stb, e_ovld, e_phase, e_busy, e_ovf}));
   end

   bit tp_on = 0;
   int tp_cyc = 0, tp_last = 0, tp_stb = 0, tp_ovld = 0, tp_badgap = 0;
   always @(negedge CLK) begin
      if (tp_on) begin
         tp_cyc++;
         if (bus.LANE_STB) begin
            if (tp_stb > 0 && (tp_cyc - tp_last) != 8) tp_badgap++;
            tp_last = tp_cyc;
            tp_stb++;
         end
         if (bus.OUT_VLD) tp_ovld++;
      end
   end

   logic rdy_g = 1'b1;
   logic clr_g = 1'b0;

   task automatic drive(input logic en, input logic vld, input logic [BW-1:0] dat);
      @(negedge CLK);
      bus.EN      = en;
      bus.IN_VLD  = vld;
      bus.IN_DAT  = dat;
      bus.DS_RDY  = rdy_g;
      bus.OVF_CLR = clr_g;
   endtask

   task automatic send(input logic [BW-1:0] dat);
      drive(1'b1, 1'b1, dat);
   endtask

   typedef struct {
      logic          en, vld;
      logic [BW-1:0] dat;
      logic          e_stb, e_ovld, e_busy, chk_dat;
      logic [2:0]    e_phase;
      logic [LW-1:0] e_lane;
   } vec_t;

   vec_t tv[17];

   task automatic chk_row(input int i);
      chk($sformatf("tbl%0d_stb", i),   64'(bus.LANE_STB), 64'(tv[i].e_stb));
      chk($sformatf("tbl%0d_ovld", i),  64'(bus.OUT_VLD),  64'(tv[i].e_ovld));
      chk($sformatf("tbl%0d_phase", i), 64'(bus.PHASE),    64'(tv[i].e_phase));
      chk($sformatf("tbl%0d_busy", i),  64'(bus.BUSY),     64'(tv[i].e_busy));
      if (tv[i].chk_dat) chk($sformatf("tbl%0d_lanes", i), 64'(bus.LANE_DAT), 64'(tv[i].e_lane));
   endtask

   logic signed [BW-1:0] gv[8];
   logic [LW-1:0]        gpack;
   int                   cnt_a, cnt_b;

   initial begin
      // Priming table: one idle->FILL cycle, then samples 1..16 back-to-back.
      tv[0] = '{en: 1'b1, vld: 1'b0, dat: '0, e_stb: 1'b0, e_ovld: 1'b0, e_busy: 1'b1,
                chk_dat: 1'b0, e_phase: 3'd0, e_lane: '0};
      for (int i = 1; i <= 16; i++) begin
         tv[i].en      = 1'b1;
         tv[i].vld     = 1'b1;
         tv[i].dat     = BW'(i);
         tv[i].e_stb   = (i % 8 == 0);
         tv[i].e_ovld  = (i == 16);
         tv[i].e_busy  = 1'b1;
         tv[i].chk_dat = (i % 8 == 0);
         tv[i].e_phase = 3'(i % 8);
         tv[i].e_lane  = pack_seq(i - 7);
      end
      gv = '{-6'sd32, 6'sd31, -6'sd1, 6'sd0, 6'sd5, -6'sd5, 6'sd17, -6'sd17};
      gpack = '0;
      for (int k = 0; k < 8; k++) gpack[k*BW +: BW] = gv[k];

      RES = 1'b0;
      bus.EN = 1'b0; bus.IN_VLD = 1'b0; bus.IN_DAT = '0; bus.DS_RDY = 1'b1; bus.OVF_CLR = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_outputs",
          64'({bus.LANE_DAT, bus.LANE_STB, bus.OUT_VLD, bus.PHASE, bus.BUSY, bus.OVF}), 64'd0);
      RES = 1'b1;
      mon_on = 1;

      // Reset asserted asynchronously mid-RUN at PHASE=5.
      drive(1'b1, 1'b0, '0);
      for (int i = 0; i < 13; i++) send(BW'(i + 3));
      @(negedge CLK);
      chk("run_phase5", 64'(bus.PHASE), 64'd5);
      bus.IN_VLD = 1'b0;
      #2 RES = 1'b0;
      #1 chk("async_reset_outputs",
             64'({bus.LANE_DAT, bus.LANE_STB, bus.OUT_VLD, bus.PHASE, bus.BUSY, bus.OVF}), 64'd0);
      drive(1'b0, 1'b1, '0);
      drive(1'b0, 1'b1, '0);
      @(negedge CLK) RES = 1'b1;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, BW'($urandom));
         if (bus.LANE_STB)    cnt_a++;
         if (bus.PHASE != 0)  cnt_b++;
      end
      chk("idle_strobes", 64'(cnt_a), 64'd0);
      chk("idle_phase_moves", 64'(cnt_b), 64'd0);
      chk("idle_busy", 64'(bus.BUSY), 64'd0);

      for (int i = 0; i < 17; i++) begin
         drive(tv[i].en, tv[i].vld, tv[i].dat);
         if (i > 0) chk_row(i - 1);
      end
      drive(1'b1, 1'b0, '0);
      chk_row(16);

      // Gapped input with signed extremes.
      cnt_a = 0;
      for (int k = 0; k < 8; k++) begin
         send(gv[k]);
         if (bus.LANE_STB) cnt_a++;
         drive(1'b1, 1'b0, '0);
         if (bus.LANE_STB && k < 7) cnt_a++;
      end
      chk("gap_early_strobes", 64'(cnt_a), 64'd0);
      chk("gap_strobe", 64'(bus.LANE_STB), 64'd1);
      chk("gap_lanes", 64'(bus.LANE_DAT), 64'(gpack));
      chk("gap_ovld", 64'(bus.OUT_VLD), 64'd1);

      // Abort after 4 samples; restart must re-prime and drop stale data.
      for (int i = 0; i < 4; i++) send(BW'(30 - i));
      drive(1'b0, 1'b1, BW'(26));
      drive(1'b1, 1'b0, '0);
      chk("abort_busy", 64'(bus.BUSY), 64'd0);
      chk("abort_phase", 64'(bus.PHASE), 64'd0);
      chk("abort_lanes_held", 64'(bus.LANE_DAT), 64'(gpack));
      for (int i = 0; i < 16; i++) begin
         send(BW'(i - 8));
         if (i == 8) begin
            chk("restart_f1_stb", 64'(bus.LANE_STB), 64'd1);
            chk("restart_f1_ovld", 64'(bus.OUT_VLD), 64'd0);
            chk("restart_f1_lanes", 64'(bus.LANE_DAT), 64'(pack_seq(-8)));
         end
      end
      drive(1'b1, 1'b0, '0);
      chk("restart_f2_stb", 64'(bus.LANE_STB), 64'd1);
      chk("restart_f2_ovld", 64'(bus.OUT_VLD), 64'd1);
      chk("restart_f2_lanes", 64'(bus.LANE_DAT), 64'(pack_seq(0)));

      // EN dropped on the edge that would close a frame.
      for (int i = 0; i < 7; i++) send(BW'(i + 10));
      drive(1'b0, 1'b1, BW'(20));
      drive(1'b1, 1'b0, '0);
      chk("drop_last_stb", 64'(bus.LANE_STB), 64'd0);
      chk("drop_last_busy", 64'(bus.BUSY), 64'd0);
      chk("drop_last_lanes", 64'(bus.LANE_DAT), 64'(pack_seq(0)));

      // Overflow: missed frame, hold, clear, and set-beats-clear.
      for (int i = 0; i < 8; i++) send(BW'(i));
      rdy_g = 1'b0;
      for (int i = 0; i < 8; i++) send(BW'(i + 1));
      drive(1'b1, 1'b0, '0);
      chk("ovf_frame_ovld", 64'(bus.OUT_VLD), 64'd1);
      drive(1'b1, 1'b0, '0);
      chk("ovf_set", 64'(bus.OVF), 64'd1);
      repeat (3) drive(1'b1, 1'b0, '0);
      chk("ovf_sticky", 64'(bus.OVF), 64'd1);
      rdy_g = 1'b1; clr_g = 1'b1;
      drive(1'b1, 1'b0, '0);
      clr_g = 1'b0;
      drive(1'b1, 1'b0, '0);
      chk("ovf_cleared", 64'(bus.OVF), 64'd0);
      for (int i = 0; i < 8; i++) send(BW'(i + 2));
      rdy_g = 1'b0; clr_g = 1'b1;
      drive(1'b1, 1'b0, '0);
      chk("ovf_coincide_ovld", 64'(bus.OUT_VLD), 64'd1);
      rdy_g = 1'b1; clr_g = 1'b0;
      drive(1'b1, 1'b0, '0);
      chk("ovf_set_wins", 64'(bus.OVF), 64'd1);
      clr_g = 1'b1;
      drive(1'b1, 1'b0, '0);
      clr_g = 1'b0;

      // Throughput: 800 continuous samples from a fresh start.
      drive(1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      tp_on = 1;
      for (int i = 0; i < 800; i++) send(BW'($urandom));
      drive(1'b1, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      tp_on = 0;
      chk("tp_strobes", 64'(tp_stb), 64'd100);
      chk("tp_out_vld", 64'(tp_ovld), 64'd99);
      chk("tp_bad_spacing", 64'(tp_badgap), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rdy_g = ($urandom_range(0, 3) != 0);
         clr_g = ($urandom_range(0, 7) == 0);
         drive(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0), BW'($urandom));
      end
      rdy_g = 1'b1; clr_g = 1'b0;
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
      mon_on = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
